fft_stage_sequencer: RTL and testbench

Control FSM for the 32-point radix-2 in-place FFT core. On `start` it steps through all five butterfly stages. Every cycle it issues a butterfly index, a stage number and the twiddle load strobe to the twiddle generator, plus a pair of read addresses to the working-set RAM. It returns a matching delayed write-back strobe and address pair once the butterfly pipeline has produced results. It owns inter-stage hazard avoidance (drain between stages) and reports `busy` and `done` to the top level.

---
 rtl/fft_pkg.sv | 15 +
 rtl/fft_wb_delay.sv | 24 ++
 rtl/fft_stage_sequencer.sv | 112 +++++++++++
 tb/tb_fft_stage_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared state encoding, stage constants and default FFT geometry
package fft_pkg;

    localparam int FFT_ADDRSIZE = 5;
    localparam int FFT_PIPE_LAT = 4;

    localparam logic [2:0] STAGE0 = 3'd0;
    localparam logic [2:0] STAGE1 = 3'd1;
    localparam logic [2:0] STAGE2 = 3'd2;
    localparam logic [2:0] STAGE3 = 3'd3;
    localparam logic [2:0] STAGE4 = 3'd4;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fft_state_e;

endpackage

// File: rtl/fft_wb_delay.sv
// fft_wb_delay: fixed-depth shift register with freeze and synchronous flush
module fft_wb_delay #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [DEPTH-1:0][W-1:0] sr;

    always_ff @(posedge clk)
        if (rst) sr <= '0;
        else if (!hold) begin
            sr[0] <= d;
            for (int j = 1; j < DEPTH; j++) sr[j] <= sr[j-1];
        end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: stage/butterfly sequencing, DIF address generation and write-back timing
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int ADDRSIZE = FFT_ADDRSIZE,
    parameter int PIPE_LAT = FFT_PIPE_LAT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                hold,
    output logic [2:0]          stage_num,
    output logic [ADDRSIZE-2:0] counter,
    output logic                ld_twiddle,
    output logic                rd_en,
    output logic [ADDRSIZE-1:0] rd_addr_a,
    output logic [ADDRSIZE-1:0] rd_addr_b,
    output logic                wr_en,
    output logic [ADDRSIZE-1:0] wr_addr_a,
    output logic [ADDRSIZE-1:0] wr_addr_b,
    output logic                busy,
    output logic                done
);

    localparam int W = 2*ADDRSIZE+1;
    localparam logic [ADDRSIZE-2:0] K_LAST = '1;
    localparam logic [2:0] S_LAST = 3'(ADDRSIZE-1);
    localparam logic [3:0] DRAIN_INIT = 4'(PIPE_LAT);

    fft_state_e state, state_d;
    logic [2:0] stage_d;
    logic [ADDRSIZE-2:0] k_d;
    logic [3:0] drain, drain_d;
    logic run, wb_valid;
    logic [W-1:0] wb_q;

    // Split k at the stage's span bit and insert the operand select there.
    function automatic logic [ADDRSIZE-1:0] ins_addr(input logic [ADDRSIZE-2:0] k,
                                                     input logic [2:0] st, input logic sel);
        logic [ADDRSIZE-1:0] kw, low_mask;
        int p;
        p = ADDRSIZE - 1 - int'(st);
        kw = ADDRSIZE'(k);
        low_mask = (ADDRSIZE'(1) << p) - ADDRSIZE'(1);
        return ((kw & ~low_mask) << 1) | (kw & low_mask) | (ADDRSIZE'(sel) << p);
    endfunction

    always_ff @(posedge clk)
        if (rst) begin
            state     <= IDLE;
            stage_num <= STAGE0;
            counter   <= '0;
            drain     <= '0;
        end else if (!hold) begin
            state     <= state_d;
            stage_num <= stage_d;
            counter   <= k_d;
            drain     <= drain_d;
        end

    always_comb begin
        state_d = state;
        stage_d = stage_num;
        k_d     = counter;
        drain_d = drain;
        case (state)
            IDLE: if (start) begin
                state_d = RUN;
                stage_d = STAGE0;
                k_d     = '0;
            end
            RUN: begin
                k_d = counter + 1'b1;
                if (counter == K_LAST) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_INIT;
                end
            end
            DRAIN: begin
                drain_d = drain - 1'b1;
                if (drain == 4'd1) begin
                    state_d = stage_num == S_LAST ? DONE : RUN;
                    stage_d = stage_num == S_LAST ? stage_num : stage_num + 1'b1;
                    k_d     = '0;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign run        = state == RUN;
    assign rd_en      = run & ~hold;
    assign ld_twiddle = rd_en;
    assign busy       = state != IDLE;
    assign done       = (state == DONE) & ~hold;
    assign rd_addr_a  = run ? ins_addr(counter, stage_num, 1'b0) : '0;
    assign rd_addr_b  = run ? ins_addr(counter, stage_num, 1'b1) : '0;

    // The delay line is keyed on the unheld read so a held cycle never loses a slot.
    fft_wb_delay #(.W(W), .DEPTH(PIPE_LAT)) u_wb (
        .clk (clk),
        .rst (rst),
        .hold(hold),
        .d   ({run, rd_addr_a, rd_addr_b}),
        .q   (wb_q)
    );

    assign {wb_valid, wr_addr_a, wr_addr_b} = wb_q;
    assign wr_en = wb_valid & ~hold;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: directed checks of sequencing, addresses, write-back, hold and reset
module tb_fft_stage_sequencer;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, hold = 1'b0;

    logic [2:0] stage_num, stage_num1;
    logic [3:0] counter, counter1;
    logic ld_twiddle, rd_en, wr_en, busy, done;
    logic ld_twiddle1, rd_en1, wr_en1, busy1, done1;
    logic [4:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [4:0] rd_addr_a1, rd_addr_b1, wr_addr_a1, wr_addr_b1;
    logic [31:0] all0, all1;

    int n_cmp = 0;
    int n_bad = 0;

    fft_stage_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .stage_num(stage_num), .counter(counter), .ld_twiddle(ld_twiddle),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
        .busy(busy), .done(done)
    );

    fft_stage_sequencer #(.ADDRSIZE(5), .PIPE_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .stage_num(stage_num1), .counter(counter1), .ld_twiddle(ld_twiddle1),
        .rd_en(rd_en1), .rd_addr_a(rd_addr_a1), .rd_addr_b(rd_addr_b1),
        .wr_en(wr_en1), .wr_addr_a(wr_addr_a1), .wr_addr_b(wr_addr_b1),
        .busy(busy1), .done(done1)
    );

    assign all0 = {stage_num, counter, ld_twiddle, rd_en, rd_addr_a, rd_addr_b,
                   wr_en, wr_addr_a, wr_addr_b, busy, done};
    assign all1 = {stage_num1, counter1, ld_twiddle1, rd_en1, rd_addr_a1, rd_addr_b1,
                   wr_en1, wr_addr_a1, wr_addr_b1, busy1, done1};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clean();
        rst = 1'b1; start = 1'b0; hold = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        #1;
        n_cmp += 2;
        if (all0 !== 32'd0) begin n_bad++; $display("FAIL reset_outputs got %h exp 0", all0); end
        if (all1 !== 32'd0) begin n_bad++; $display("FAIL reset_outputs_lat1 got %h exp 0", all1); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [4:0] ra [0:127];
        logic [4:0] rb [0:127];
        logic [9:0] sp;
        int nr, nw;
        bit er, ew;
        clean();
        nr = 0; nw = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 110; c++) begin
            #1;
            er = c <= 100 && (c - 1) % 20 < 16;
            ew = c >= 5 && c <= 104 && (c - 5) % 20 < 16;
            n_cmp += 5;
            if (rd_en !== er) begin n_bad++; $display("FAIL rd_en c=%0d got %b exp %b", c, rd_en, er); end
            if (ld_twiddle !== er) begin n_bad++; $display("FAIL ld_twiddle c=%0d got %b exp %b", c, ld_twiddle, er); end
            if (wr_en !== ew) begin n_bad++; $display("FAIL wr_en c=%0d got %b exp %b", c, wr_en, ew); end
            if (busy !== (c <= 101)) begin n_bad++; $display("FAIL busy c=%0d got %b", c, busy); end
            if (done !== (c == 101)) begin n_bad++; $display("FAIL done c=%0d got %b", c, done); end
            if (er) begin
                ra[c] = rd_addr_a; rb[c] = rd_addr_b; nr++;
                n_cmp++;
                if ({stage_num, counter} !== {3'((c - 1) / 20), 4'((c - 1) % 20)}) begin
                    n_bad++; $display("FAIL stage_k c=%0d got %0d/%0d exp %0d/%0d", c, stage_num, counter, (c - 1) / 20, (c - 1) % 20);
                end
            end
            if (wr_en && c > 4) begin
                nw++;
                n_cmp++;
                if ({wr_addr_a, wr_addr_b} !== {ra[c-4], rb[c-4]}) begin
                    n_bad++; $display("FAIL wr_addr c=%0d got %0d/%0d exp %0d/%0d", c, wr_addr_a, wr_addr_b, ra[c-4], rb[c-4]);
                end
            end
            if (c == 4 || c == 46 || c == 84) begin
                sp = c == 4 ? {5'd3, 5'd19} : c == 46 ? {5'd9, 5'd13} : {5'd6, 5'd7};
                n_cmp++;
                if ({rd_addr_a, rd_addr_b} !== sp) begin
                    n_bad++; $display("FAIL rd_addr c=%0d got %0d/%0d exp %0d/%0d", c, rd_addr_a, rd_addr_b, sp[9:5], sp[4:0]);
                end
            end
            tick();
        end
        n_cmp += 2;
        if (nr !== 80) begin n_bad++; $display("FAIL read_count got %0d exp 80", nr); end
        if (nw !== 80) begin n_bad++; $display("FAIL write_count got %0d exp 80", nw); end
    endtask

    task automatic test_start_held();
        int busy_n, done_n;
        clean();
        busy_n = 0; done_n = 0;
        start = 1'b1;
        tick();
        for (int c = 1; c <= 102; c++) begin
            #1;
            if (c <= 101) begin busy_n += int'(busy); done_n += int'(done); end
            if (c == 101) begin
                n_cmp++;
                if (done !== 1'b1) begin n_bad++; $display("FAIL held_done c=101 got %b exp 1", done); end
            end
            if (c == 102) begin
                n_cmp++;
                if (busy !== 1'b0) begin n_bad++; $display("FAIL held_idle c=102 got %b exp 0", busy); end
            end
            tick();
        end
        #1;
        n_cmp += 3;
        if ({busy, rd_en, stage_num, counter} !== {2'b11, 3'd0, 4'd0}) begin
            n_bad++; $display("FAIL held_restart got %b/%b/%0d/%0d exp 1/1/0/0", busy, rd_en, stage_num, counter);
        end
        if (busy_n !== 101) begin n_bad++; $display("FAIL held_busy_cycles got %0d exp 101", busy_n); end
        if (done_n !== 1) begin n_bad++; $display("FAIL held_done_count got %0d exp 1", done_n); end
        start = 1'b0;
        tick();
        for (int c = 104; c <= 215; c++) begin
            start = c == 110;
            #1;
            n_cmp += 2;
            if (done !== (c == 203)) begin n_bad++; $display("FAIL pulse_done c=%0d got %b", c, done); end
            if (busy !== (c <= 203)) begin n_bad++; $display("FAIL pulse_busy c=%0d got %b", c, busy); end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_hold();
        clean();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 112; c++) begin
            hold = c >= 27 && c <= 33;
            #1;
            if (hold) begin
                n_cmp++;
                if ({rd_en, ld_twiddle, wr_en, stage_num, counter} !== {3'b000, 3'd1, 4'd6}) begin
                    n_bad++; $display("FAIL hold_frozen c=%0d got %b%b%b %0d/%0d exp 000 1/6", c, rd_en, ld_twiddle, wr_en, stage_num, counter);
                end
            end
            if (c == 34 || c == 35) begin
                n_cmp++;
                if ({rd_en, stage_num, counter} !== {1'b1, 3'd1, c == 34 ? 4'd6 : 4'd7}) begin
                    n_bad++; $display("FAIL hold_resume c=%0d got %b %0d/%0d", c, rd_en, stage_num, counter);
                end
            end
            n_cmp++;
            if (done !== (c == 108)) begin n_bad++; $display("FAIL hold_done c=%0d got %b", c, done); end
            tick();
        end
        hold = 1'b0;
    endtask

    task automatic test_reset_mid();
        int nw;
        clean();
        nw = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 77; c++) tick();
        #1;
        n_cmp++;
        if ({busy, rd_en, stage_num} !== {2'b10, 3'd3}) begin
            n_bad++; $display("FAIL mid_drain got %b%b %0d exp 10 3", busy, rd_en, stage_num);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp += 2;
        if (all0 !== 32'd0) begin n_bad++; $display("FAIL mid_reset_outputs got %h exp 0", all0); end
        if (all1 !== 32'd0) begin n_bad++; $display("FAIL mid_reset_outputs_lat1 got %h exp 0", all1); end
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            n_cmp++;
            if ({wr_en, busy} !== 2'b00) begin n_bad++; $display("FAIL post_reset_quiet i=%0d got %b exp 00", i, {wr_en, busy}); end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 105; c++) begin
            #1;
            nw += int'(wr_en);
            n_cmp++;
            if (done !== (c == 101)) begin n_bad++; $display("FAIL rerun_done c=%0d got %b", c, done); end
            tick();
        end
        n_cmp++;
        if (nw !== 80) begin n_bad++; $display("FAIL rerun_writes got %0d exp 80", nw); end
    endtask

    task automatic test_pipe_lat1();
        logic pr;
        logic [9:0] pa;
        int nw, lastw;
        clean();
        pr = 1'b0; pa = '0; nw = 0; lastw = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 92; c++) begin
            #1;
            n_cmp += 3;
            if (done1 !== (c == 86)) begin n_bad++; $display("FAIL lat1_done c=%0d got %b", c, done1); end
            if (busy1 !== (c <= 86)) begin n_bad++; $display("FAIL lat1_busy c=%0d got %b", c, busy1); end
            if (wr_en1 !== pr) begin n_bad++; $display("FAIL lat1_wr_en c=%0d got %b exp %b", c, wr_en1, pr); end
            if (pr) begin
                n_cmp++;
                if ({wr_addr_a1, wr_addr_b1} !== pa) begin
                    n_bad++; $display("FAIL lat1_wr_addr c=%0d got %0d/%0d exp %0d/%0d", c, wr_addr_a1, wr_addr_b1, pa[9:5], pa[4:0]);
                end
            end
            if (wr_en1) begin nw++; lastw = c; end
            if (rd_en1 && counter1 == 4'd0 && stage_num1 != 3'd0) begin
                n_cmp++;
                if (nw != 16 * int'(stage_num1) || lastw != c - 1) begin
                    n_bad++; $display("FAIL lat1_boundary c=%0d writes %0d last %0d exp %0d last %0d", c, nw, lastw, 16 * int'(stage_num1), c - 1);
                end
            end
            pr = rd_en1;
            pa = {rd_addr_a1, rd_addr_b1};
            tick();
        end
        n_cmp++;
        if (nw !== 80) begin n_bad++; $display("FAIL lat1_writes got %0d exp 80", nw); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_start_held();
        test_hold();
        test_reset_mid();
        test_pipe_lat1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
